// File: rtl/eth_pkt_fifo.sv
// Ethernet packet FIFO with optional store-and-forward frame dropping.
// Beats are stored as {tlast, tkeep, tdata}; tuser only steers the commit/drop
// decision. The master side is a single output register that always holds
// the entry at rd_ptr, so rd_ptr (and occupancy) only moves when a beat is
// actually handed downstream.
//
// state | meaning
// IDLE  | between frames, wr_ptr == commit_ptr
// RECV  | mid-frame, beats written beyond commit_ptr
// DROP  | frame overflowed, discard beats until tlast
module eth_pkt_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 2048,
  parameter int STORE_FWD = 1,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          s_axis_tdata,
  input  logic [DATA_W/8-1:0]        s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  input  logic                       s_axis_tuser,
  output logic                       s_axis_tready,
  output logic [DATA_W-1:0]          m_axis_tdata,
  output logic [DATA_W/8-1:0]        m_axis_tkeep,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [CNT_W-1:0]           frame_cnt,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int KW = DATA_W / 8;
  localparam int EW = DATA_W + KW + 1;
  localparam logic [AW:0] DEPTH_P = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, commit_ptr, rd_ptr;
  logic [AW:0]   wr_ptr_nxt, commit_ptr_nxt, rd_fetch, rd_lim;
  state_t        state, state_nxt;
  logic          rdy_en, full, s_fire, m_fire, fetch;
  logic          mem_we, frame_inc, drop_inc, ovf_nxt;

  assign full      = (wr_ptr - rd_ptr) == DEPTH_P;
  assign occupancy = wr_ptr - rd_ptr;
  assign s_fire    = s_axis_tvalid && s_axis_tready;
  assign m_fire    = m_axis_tvalid && m_axis_tready;
  // In store-and-forward only committed beats are visible to the reader.
  assign rd_lim    = (STORE_FWD != 0) ? commit_ptr : wr_ptr;
  assign rd_fetch  = m_axis_tvalid ? rd_ptr + 1'b1 : rd_ptr;
  assign fetch     = (!m_axis_tvalid || m_axis_tready) && (rd_fetch != rd_lim);

  // Slave ready: held low in reset and for the first cycle after; DROP swallows beats.
  always_comb begin
    s_axis_tready = 1'b0;
    if (rdy_en) begin
      if ((STORE_FWD != 0) && (state == DROP)) s_axis_tready = 1'b1;
      else                                     s_axis_tready = !full;
    end
  end

  // Input FSM next-state, pointer updates and counter strobes.
  always_comb begin
    state_nxt      = state;
    wr_ptr_nxt     = wr_ptr;
    commit_ptr_nxt = commit_ptr;
    mem_we         = 1'b0;
    frame_inc      = 1'b0;
    drop_inc       = 1'b0;
    ovf_nxt        = 1'b0;
    if (STORE_FWD == 0) begin
      if (s_fire) begin
        mem_we         = 1'b1;
        wr_ptr_nxt     = wr_ptr + 1'b1;
        commit_ptr_nxt = wr_ptr + 1'b1;
        frame_inc      = s_axis_tlast;
      end
    end else begin
      case (state)
        IDLE: begin
          if (s_fire) begin
            if (s_axis_tlast && s_axis_tuser) begin
              drop_inc = 1'b1;
            end else begin
              mem_we     = 1'b1;
              wr_ptr_nxt = wr_ptr + 1'b1;
              if (s_axis_tlast) begin
                commit_ptr_nxt = wr_ptr + 1'b1;
                frame_inc      = 1'b1;
              end else begin
                state_nxt = RECV;
              end
            end
          end
        end
        RECV: begin
          if (s_fire) begin
            if (s_axis_tlast && s_axis_tuser) begin
              wr_ptr_nxt = commit_ptr;
              drop_inc   = 1'b1;
              state_nxt  = IDLE;
            end else begin
              mem_we     = 1'b1;
              wr_ptr_nxt = wr_ptr + 1'b1;
              if (s_axis_tlast) begin
                commit_ptr_nxt = wr_ptr + 1'b1;
                frame_inc      = 1'b1;
                state_nxt      = IDLE;
              end
            end
          end else if (s_axis_tvalid && full) begin
            // Frame cannot fit: rewind and discard the remainder.
            wr_ptr_nxt = commit_ptr;
            ovf_nxt    = 1'b1;
            drop_inc   = 1'b1;
            state_nxt  = DROP;
          end
        end
        DROP: begin
          if (s_fire && s_axis_tlast) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Write-side state: FSM, pointers, counters, overflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rdy_en     <= 1'b0;
      overflow   <= 1'b0;
      frame_cnt  <= '0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      commit_ptr <= commit_ptr_nxt;
      rdy_en     <= 1'b1;
      overflow   <= ovf_nxt;
      if (frame_inc && (frame_cnt != {CNT_W{1'b1}})) frame_cnt <= frame_cnt + 1'b1;
      if (drop_inc && (drop_cnt != {CNT_W{1'b1}}))   drop_cnt  <= drop_cnt + 1'b1;
    end
  end

  // Packet RAM write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  end

  // Output register holding mem[rd_ptr]; rd_ptr frees an entry only on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tkeep  <= '0;
      m_axis_tdata  <= '0;
    end else begin
      if (m_fire) rd_ptr <= rd_ptr + 1'b1;
      if (fetch) begin
        m_axis_tvalid <= 1'b1;
        {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= mem[rd_fetch[AW-1:0]];
      end else if (m_fire) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eth_pkt_fifo.sv
// Bench for eth_pkt_fifo: three instances (8-bit store-and-forward, 32-bit
// 16-deep store-and-forward, 8-bit 16-deep cut-through). Stimulus pushes the
// expected beats into per-channel queues; negedge monitors pop and compare.
module tb_eth_pkt_fifo;

  logic        clk, rst_n;
  logic [31:0] sdata [3];
  logic [3:0]  skeep [3];
  logic        svalid [3], slast [3], suser [3], mready [3];
  wire         sready [3], mvalid [3], mlast [3], ovf [3];
  wire  [15:0] fcnt [3], dcnt [3];
  wire  [31:0] mdata [3];
  wire  [3:0]  mkeep [3];
  wire  [7:0]  occ [3];
  wire  [7:0]  md0, md2, oc0;
  wire  [31:0] md1;
  wire  [3:0]  mk1;
  wire         mk0, mk2;
  wire  [4:0]  oc1, oc2;

  assign mdata[0] = {24'd0, md0};
  assign mdata[1] = md1;
  assign mdata[2] = {24'd0, md2};
  assign mkeep[0] = {3'd0, mk0};
  assign mkeep[1] = mk1;
  assign mkeep[2] = {3'd0, mk2};
  assign occ[0]   = oc0;
  assign occ[1]   = {3'd0, oc1};
  assign occ[2]   = {3'd0, oc2};

  eth_pkt_fifo #(.DATA_W(8), .DEPTH(128), .STORE_FWD(1), .CNT_W(16)) u_sf8 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(sdata[0][7:0]), .s_axis_tkeep(skeep[0][0:0]), .s_axis_tvalid(svalid[0]),
    .s_axis_tlast(slast[0]), .s_axis_tuser(suser[0]), .s_axis_tready(sready[0]),
    .m_axis_tdata(md0), .m_axis_tkeep(mk0), .m_axis_tvalid(mvalid[0]),
    .m_axis_tlast(mlast[0]), .m_axis_tready(mready[0]),
    .occupancy(oc0), .frame_cnt(fcnt[0]), .drop_cnt(dcnt[0]), .overflow(ovf[0]));

  eth_pkt_fifo #(.DATA_W(32), .DEPTH(16), .STORE_FWD(1), .CNT_W(16)) u_sf32 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(sdata[1]), .s_axis_tkeep(skeep[1]), .s_axis_tvalid(svalid[1]),
    .s_axis_tlast(slast[1]), .s_axis_tuser(suser[1]), .s_axis_tready(sready[1]),
    .m_axis_tdata(md1), .m_axis_tkeep(mk1), .m_axis_tvalid(mvalid[1]),
    .m_axis_tlast(mlast[1]), .m_axis_tready(mready[1]),
    .occupancy(oc1), .frame_cnt(fcnt[1]), .drop_cnt(dcnt[1]), .overflow(ovf[1]));

  eth_pkt_fifo #(.DATA_W(8), .DEPTH(16), .STORE_FWD(0), .CNT_W(16)) u_ct8 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(sdata[2][7:0]), .s_axis_tkeep(skeep[2][0:0]), .s_axis_tvalid(svalid[2]),
    .s_axis_tlast(slast[2]), .s_axis_tuser(suser[2]), .s_axis_tready(sready[2]),
    .m_axis_tdata(md2), .m_axis_tkeep(mk2), .m_axis_tvalid(mvalid[2]),
    .m_axis_tlast(mlast[2]), .m_axis_tready(mready[2]),
    .occupancy(oc2), .frame_cnt(fcnt[2]), .drop_cnt(dcnt[2]), .overflow(ovf[2]));

  int          errors = 0;
  int          checks = 0;
  int          acc [3];
  int          ovf_n [3];
  logic        rnd_en;
  logic [36:0] exp_q [3][$];
  logic [36:0] prev_beat [3];
  logic        prev_stall [3];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int ch, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s ch=%0d got=%0h required=%0h", name, ch, got, exp);
    end
  endtask

  // Output monitors: scoreboard pop on handshake, hold-stable check while stalled.
  for (genvar g = 0; g < 3; g++) begin : g_mon
    always @(negedge clk) begin
      logic [36:0] beat, exp;
      beat = {mlast[g], mkeep[g], mdata[g]};
      if (!rst_n) begin
        prev_stall[g] = 1'b0;
      end else begin
        if (prev_stall[g])
          chk("stall_hold", g, {26'd0, mvalid[g], beat}, {26'd0, 1'b1, prev_beat[g]});
        if (mvalid[g] && mready[g]) begin
          if (exp_q[g].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out ch=%0d got=%0h required=none", g, beat);
          end else begin
            exp = exp_q[g].pop_front();
            chk("out_beat", g, {27'd0, beat}, {27'd0, exp});
          end
        end
        prev_stall[g] = mvalid[g] && !mready[g];
        prev_beat[g]  = beat;
      end
    end
  end

  // Overflow monitor: only the 32-bit store-and-forward channel may pulse, at beat 17.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < 3; c++) begin
        if (ovf[c]) begin
          ovf_n[c]++;
          if (c == 1) chk("ovf_at_beat", c, 64'(acc[c]), 64'd16);
          else        chk("ovf_unexpected", c, 64'(ovf[c]), 64'd0);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_en) mready[1] = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input int ch, input logic [31:0] d, input logic [3:0] k,
                      input logic l, input logic u, input logic push);
    int n;
    n = 0;
    sdata[ch] = d; skeep[ch] = k; slast[ch] = l; suser[ch] = u; svalid[ch] = 1'b1;
    @(negedge clk);
    while (!sready[ch] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!sready[ch]) begin
      checks++;
      errors++;
      $display("FAIL send_timeout ch=%0d got=ready_low required=accept", ch);
      svalid[ch] = 1'b0;
      return;
    end
    if (push) exp_q[ch].push_back({l, k, d});
    @(posedge clk);
    acc[ch]++;
    #1;
    svalid[ch] = 1'b0;
  endtask

  task automatic wait_drain(input int ch);
    int n;
    n = 0;
    while ((exp_q[ch].size() != 0 || mvalid[ch]) && n < 600) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q[ch].size() != 0 || mvalid[ch]) begin
      errors++;
      $display("FAIL drain ch=%0d got=remaining_%0d required=0", ch, exp_q[ch].size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    for (int c = 0; c < 3; c++) begin
      chk("rst_sready", c, 64'(sready[c]), 64'd0);
      chk("rst_mvalid", c, 64'(mvalid[c]), 64'd0);
      chk("rst_mlast",  c, 64'(mlast[c]),  64'd0);
      chk("rst_mdata",  c, 64'(mdata[c]),  64'd0);
      chk("rst_mkeep",  c, 64'(mkeep[c]),  64'd0);
      chk("rst_occ",    c, 64'(occ[c]),    64'd0);
      chk("rst_ovf",    c, 64'(ovf[c]),    64'd0);
      chk("rst_fcnt",   c, 64'(fcnt[c]),   64'd0);
      chk("rst_dcnt",   c, 64'(dcnt[c]),   64'd0);
    end
  endtask

  // Asserts reset mid-cycle, checks outputs while held, releases at posedge+1.
  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      svalid[c] = 1'b0;
      exp_q[c].delete();
      acc[c] = 0;
    end
    #2;
    check_reset_vals();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rnd_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sdata[c] = '0; skeep[c] = '0; svalid[c] = 1'b0; slast[c] = 1'b0;
      suser[c] = 1'b0; mready[c] = 1'b0; acc[c] = 0; ovf_n[c] = 0;
      prev_stall[c] = 1'b0; prev_beat[c] = '0;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 64-byte good frame, store-and-forward: no output until after commit.
    mready[0] = 1'b1;
    for (int i = 0; i < 64; i++) send(0, 32'(i), 4'h1, (i == 63), 1'b0, 1'b1);
    @(negedge clk);
    chk("sf_lat_edge_n", 0, 64'(mvalid[0]), 64'd0);
    @(negedge clk);
    chk("sf_lat_edge_n1", 0, 64'(mvalid[0]), 64'd1);
    wait_drain(0);
    chk("sf64_fcnt", 0, 64'(fcnt[0]), 64'd1);
    chk("sf64_dcnt", 0, 64'(dcnt[0]), 64'd0);
    chk("sf64_occ",  0, 64'(occ[0]),  64'd0);

    // Bad frame A then good frame B, then single-beat good and bad frames.
    apply_reset();
    mready[0] = 1'b1;
    for (int i = 0; i < 6; i++) send(0, 32'hA0 + 32'(i), 4'h1, (i == 5), (i == 5), 1'b0);
    for (int i = 0; i < 4; i++) send(0, 32'hB0 + 32'(i), 4'h1, (i == 3), 1'b0, 1'b1);
    wait_drain(0);
    chk("ab_dcnt", 0, 64'(dcnt[0]), 64'd1);
    chk("ab_fcnt", 0, 64'(fcnt[0]), 64'd1);
    chk("ab_occ",  0, 64'(occ[0]),  64'd0);
    send(0, 32'hC5, 4'h1, 1'b1, 1'b0, 1'b1);
    send(0, 32'hD6, 4'h1, 1'b1, 1'b1, 1'b0);
    wait_drain(0);
    chk("single_fcnt", 0, 64'(fcnt[0]), 64'd2);
    chk("single_dcnt", 0, 64'(dcnt[0]), 64'd2);

    // 20-beat frame into 16-deep store-and-forward with output stalled.
    mready[1] = 1'b0;
    acc[1] = 0;
    for (int i = 0; i < 20; i++) send(1, 32'h1000 + 32'(i), 4'hF, (i == 19), 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("ovf_dcnt",   1, 64'(dcnt[1]),   64'd1);
    chk("ovf_fcnt",   1, 64'(fcnt[1]),   64'd0);
    chk("ovf_occ",    1, 64'(occ[1]),    64'd0);
    chk("ovf_pulses", 1, 64'(ovf_n[1]),  64'd1);
    chk("ovf_mvalid", 1, 64'(mvalid[1]), 64'd0);
    chk("ovf_acc",    1, 64'(acc[1]),    64'd20);

    // 32-bit frames with random output backpressure; tkeep must survive.
    @(posedge clk);
    #1;
    rnd_en = 1'b1;
    send(1, 32'h44332211, 4'hF, 1'b0, 1'b0, 1'b1);
    send(1, 32'h00000055, 4'h1, 1'b1, 1'b0, 1'b1);
    send(1, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 1'b1);
    send(1, 32'hCAFE0102, 4'hF, 1'b0, 1'b0, 1'b1);
    send(1, 32'h00000A0B, 4'h3, 1'b1, 1'b0, 1'b1);
    wait_drain(1);
    rnd_en = 1'b0;
    mready[1] = 1'b1;
    chk("k32_fcnt", 1, 64'(fcnt[1]), 64'd2);
    chk("k32_dcnt", 1, 64'(dcnt[1]), 64'd1);

    // Cut-through, 16 deep, output stalled: backpressure at 16, then drain all 20.
    mready[2] = 1'b0;
    acc[2] = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) send(2, 32'h30 + 32'(i), 4'h1, (i == 19), 1'b0, 1'b1);
      end
      begin
        int n;
        n = 0;
        while (acc[2] < 16 && n < 200) begin
          @(negedge clk);
          n++;
        end
        repeat (3) @(negedge clk);
        chk("ct_acc_hold", 2, 64'(acc[2]),   64'd16);
        chk("ct_sready",   2, 64'(sready[2]), 64'd0);
        chk("ct_occ",      2, 64'(occ[2]),    64'd16);
        chk("ct_mvalid",   2, 64'(mvalid[2]), 64'd1);
        @(posedge clk);
        #1;
        mready[2] = 1'b1;
      end
    join
    wait_drain(2);
    chk("ct_fcnt", 2, 64'(fcnt[2]), 64'd1);
    chk("ct_dcnt", 2, 64'(dcnt[2]), 64'd0);
    chk("ct_occ_end", 2, 64'(occ[2]), 64'd0);

    // Reset with a committed frame queued and a partial frame in flight.
    mready[0] = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 32'h60 + 32'(i), 4'h1, (i == 3), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) send(0, 32'h70 + 32'(i), 4'h1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("pre_rst_mvalid", 0, 64'(mvalid[0]), 64'd1);
    apply_reset();
    mready[0] = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_mvalid", 0, 64'(mvalid[0]), 64'd0);
    chk("post_rst_occ",    0, 64'(occ[0]),    64'd0);
    @(posedge clk);
    #1;
    send(0, 32'h81, 4'h1, 1'b0, 1'b0, 1'b1);
    send(0, 32'h82, 4'h1, 1'b1, 1'b0, 1'b1);
    wait_drain(0);
    chk("post_rst_fcnt", 0, 64'(fcnt[0]), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_pkt_fifo.md
ETH_PKT_FIFO -- requirements
Module: eth_pkt_fifo

Interface
REQ-001 Parameters: DATA_W, 8, beat width in bits (8/16/32); DEPTH, 2048, RAM entries (power of 2, >=16); STORE_FWD, 1, 1 = store-and-forward with frame drop, 0 = cut-through; CNT_W, 16, statistics counter width.
REQ-002 Ports: clk  in  1  single clock, all logic on rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-003 Ports: s_axis_tdata in DATA_W, s_axis_tkeep in DATA_W/8, s_axis_tvalid in 1, s_axis_tlast in 1, s_axis_tuser in 1 (1 on tlast beat = bad frame, e.g. FCS error), s_axis_tready out 1.
REQ-004 Ports: m_axis_tdata out DATA_W, m_axis_tkeep out DATA_W/8, m_axis_tvalid out 1, m_axis_tlast out 1, m_axis_tready in 1.
REQ-005 Ports: occupancy out log2(DEPTH)+1 (written-but-unread entries incl. uncommitted); frame_cnt out CNT_W (frames committed); drop_cnt out CNT_W (frames dropped); overflow out 1 (one-cycle pulse per overflow drop).

Function
REQ-006 Beat transfer on either port only when tvalid and tready are both high at a rising edge; tdata/tkeep/tlast stored and replayed unmodified; tuser not stored.
REQ-007 Pointers wr_ptr, commit_ptr, rd_ptr are log2(DEPTH)+1 bits with wrap bit; full = (wr_ptr-rd_ptr)==DEPTH; occupancy = wr_ptr-rd_ptr.
REQ-008 Latency: beat visible at master no earlier than one edge after the edge it becomes readable (edge N write/commit -> m_axis_tvalid high after edge N+1).
REQ-009 m_axis_tvalid, once high, holds with data stable until accepted (no retraction).
REQ-010 STORE_FWD=0: readable = written; s_axis_tready = !full; no drops; tuser ignored; frame_cnt increments on every accepted s tlast; drop_cnt stays 0.
REQ-011 STORE_FWD=1: readable region is rd_ptr..commit_ptr only; uncommitted beats never presented on master.
REQ-012 STORE_FWD=1 input FSM states: IDLE, RECV, DROP.
REQ-013 IDLE -> RECV on first accepted beat without tlast; single-beat frame (tlast on first beat) commits or drops directly, staying IDLE.
REQ-014 RECV: s_axis_tready=1 while !full; tlast with tuser=0 -> commit_ptr<=wr_ptr+1, frame_cnt++, IDLE; tlast with tuser=1 -> wr_ptr<=commit_ptr, drop_cnt++, IDLE.
REQ-015 RECV with s_axis_tvalid high and full -> wr_ptr<=commit_ptr, overflow pulse, drop_cnt++, DROP (beat not written).
REQ-016 DROP: s_axis_tready=1, beats discarded; accepted tlast -> IDLE; no further counter change.
REQ-017 Frame longer than DEPTH is always dropped via REQ-015; FIFO never deadlocks.
REQ-018 Full evaluated on registered pointers; read freeing an entry on edge N allows write from edge N+1 (no same-cycle bypass).
REQ-019 Simultaneous commit and read in same cycle both take effect; occupancy reflects both.
REQ-020 frame_cnt, drop_cnt saturate at all-ones, no wrap.
REQ-021 Cut-through mode at full: s_axis_tready low, backpressure only, no overflow pulse.

Reset
REQ-022 rst_n low asynchronously clears all pointers, FSM to IDLE, counters to 0; outputs: s_axis_tready 0, m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata/tkeep 0, occupancy 0, overflow 0.
REQ-023 s_axis_tready may rise from the first edge after rst_n deasserts; RAM contents need no reset.
REQ-024 Reset mid-frame discards all stored and in-flight frames; no partial frame emitted afterwards.

Verification
REQ-025 SF, 64-byte frame 0x00..0x3F, tuser=0, m_axis_tready=1 -> 64 identical beats, tlast on 0x3F, first m tvalid not before edge after tlast accepted, frame_cnt=1.
REQ-026 SF, frame A tuser=1 then frame B good -> only B emitted, drop_cnt=1, frame_cnt=1, occupancy 0 after drain.
REQ-027 SF, DEPTH=16, m_axis_tready=0, 20-beat frame -> overflow pulse at beat 17, remaining beats accepted, no output, drop_cnt=1, occupancy 0.
REQ-028 CT, DEPTH=16, m_axis_tready=0, 20 beats -> s_axis_tready low after 16, occupancy 16; release tready -> all 20 emitted in order.
REQ-029 SF, rst_n pulsed low mid-frame with committed frame queued -> all outputs reset values immediately, no data after release, counters 0.
REQ-030 SF, DATA_W=32, 5-byte frame (tkeep 0xF then 0x1) with random m_axis_tready -> two beats, tkeep preserved, data stable while stalled.
